// File: rtl/mvm_pkg.sv
// Shared types and helpers for the fully-connected layer controller.
package mvm_pkg;

  typedef enum logic [1:0] {
    LOAD,
    COMPUTE,
    DRAIN,
    OUTPUT
  } mvm_state_t;

  // Address/select width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mvm_wrap_cnt.sv
// Modulo-MAX counter: advances on i_inc, wraps to 0 after MAX-1, o_last flags the final value.
module mvm_wrap_cnt
  import mvm_pkg::*;
#(
  parameter int unsigned MAX = 2,
  localparam int unsigned W = clog2_min1(MAX)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt,
  output logic         o_last
);

  localparam logic [W-1:0] LastVal = W'(MAX - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= o_last ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_last = (r_cnt == LastVal);

endmodule

// File: rtl/mvm_layer_ctrl.sv
// Sequencer for one y = W*x layer: loads x, runs M/P column sweeps over P MACs,
// waits out the MAC pipeline, then serialises the P accumulators per pass.
module mvm_layer_ctrl
  import mvm_pkg::*;
#(
  parameter int unsigned M       = 64,
  parameter int unsigned N       = 33,
  parameter int unsigned P       = 16,
  parameter int unsigned MAC_LAT = 2,
  localparam int unsigned XAW = clog2_min1(N),
  localparam int unsigned WAW = clog2_min1(M / P * N),
  localparam int unsigned SW  = clog2_min1(P)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           s_valid_x,
  output logic           s_ready_x,
  output logic           m_valid_y,
  input  logic           m_ready_y,
  output logic           x_wr_en,
  output logic [XAW-1:0] x_addr,
  output logic [WAW-1:0] w_addr,
  output logic           mac_en,
  output logic           mac_clear,
  output logic [SW-1:0]  out_sel
);

  localparam int unsigned NPass  = M / P;
  localparam int unsigned DrnMax = (MAC_LAT == 0) ? 1 : MAC_LAT;
  localparam int unsigned PW     = clog2_min1(NPass);
  localparam int unsigned DW     = clog2_min1(DrnMax);

  mvm_state_t r_state, w_state_next;

  logic           w_x_hs, w_y_hs, w_to_load;
  logic           w_col_inc, w_pass_inc, w_drn_inc, w_k_inc;
  logic           w_col_last, w_pass_last, w_drn_last, w_k_last;
  logic [XAW-1:0] w_col;
  logic [PW-1:0]  w_pass;
  logic [DW-1:0]  w_drn;
  logic [SW-1:0]  w_k;
  logic [WAW-1:0] r_waddr;
  logic           w_unused_cnt;

  assign w_x_hs = s_valid_x & s_ready_x;
  assign w_y_hs = m_valid_y & m_ready_y;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_col_inc    = 1'b0;
    w_pass_inc   = 1'b0;
    w_drn_inc    = 1'b0;
    w_k_inc      = 1'b0;
    w_to_load    = 1'b0;
    unique case (r_state)
      LOAD: begin
        w_col_inc = w_x_hs;
        if (w_x_hs && w_col_last) w_state_next = COMPUTE;
      end
      COMPUTE: begin
        w_col_inc = 1'b1;
        if (w_col_last) w_state_next = (MAC_LAT == 0) ? OUTPUT : DRAIN;
      end
      DRAIN: begin
        w_drn_inc = 1'b1;
        if (w_drn_last) w_state_next = OUTPUT;
      end
      OUTPUT: begin
        w_k_inc = w_y_hs;
        if (w_y_hs && w_k_last) begin
          w_pass_inc = 1'b1;
          if (w_pass_last) begin
            w_state_next = LOAD;
            w_to_load    = 1'b1;
          end else begin
            w_state_next = COMPUTE;
          end
        end
      end
      default: w_state_next = LOAD;
    endcase
  end

  // Shared by the load write pointer and the compute column index.
  mvm_wrap_cnt #(.MAX(N)) u_col_cnt (
    .clk    (clk),
    .reset  (reset),
    .i_inc  (w_col_inc),
    .i_clr  (1'b0),
    .o_cnt  (w_col),
    .o_last (w_col_last)
  );

  mvm_wrap_cnt #(.MAX(NPass)) u_pass_cnt (
    .clk    (clk),
    .reset  (reset),
    .i_inc  (w_pass_inc),
    .i_clr  (1'b0),
    .o_cnt  (w_pass),
    .o_last (w_pass_last)
  );

  mvm_wrap_cnt #(.MAX(DrnMax)) u_drn_cnt (
    .clk    (clk),
    .reset  (reset),
    .i_inc  (w_drn_inc),
    .i_clr  (1'b0),
    .o_cnt  (w_drn),
    .o_last (w_drn_last)
  );

  mvm_wrap_cnt #(.MAX(P)) u_k_cnt (
    .clk    (clk),
    .reset  (reset),
    .i_inc  (w_k_inc),
    .i_clr  (1'b0),
    .o_cnt  (w_k),
    .o_last (w_k_last)
  );

  assign w_unused_cnt = ^{w_pass, w_drn};

  // Running weight address equals pass*N+col without a multiplier.
  always_ff @(posedge clk) begin
    if (reset || w_to_load) begin
      r_waddr <= '0;
    end else if (mac_en) begin
      r_waddr <= r_waddr + 1'b1;
    end
  end

  assign s_ready_x = (r_state == LOAD);
  assign m_valid_y = (r_state == OUTPUT);
  assign x_wr_en   = w_x_hs & ~reset;
  assign mac_en    = (r_state == COMPUTE);
  assign mac_clear = mac_en & (w_col == '0);
  assign x_addr    = w_col;
  assign w_addr    = r_waddr;
  assign out_sel   = w_k;

endmodule

// File: tb/tb_mvm_layer_ctrl.sv
// Self-checking bench: drives vectors through the controller and scores a behavioural
// datapath (x RAM, weight ROMs, accumulators) against a plain matrix-vector product.
module tb_mvm_layer_ctrl;

  localparam int unsigned M       = 64;
  localparam int unsigned N       = 33;
  localparam int unsigned P       = 16;
  localparam int unsigned MAC_LAT = 2;
  localparam int unsigned NPASS   = M / P;
  localparam int unsigned XAW     = (N <= 2) ? 1 : $clog2(N);
  localparam int unsigned WAW     = (NPASS * N <= 2) ? 1 : $clog2(NPASS * N);
  localparam int unsigned SW      = (P <= 2) ? 1 : $clog2(P);
  localparam int          VEC_CYCLES = N + NPASS * (N + MAC_LAT + P);

  logic           clk = 1'b0;
  logic           reset;
  logic           s_valid_x;
  logic           s_ready_x;
  logic           m_valid_y;
  logic           m_ready_y;
  logic           x_wr_en;
  logic [XAW-1:0] x_addr;
  logic [WAW-1:0] w_addr;
  logic           mac_en;
  logic           mac_clear;
  logic [SW-1:0]  out_sel;

  int n_total = 0;
  int n_bad   = 0;

  int x_vec [N];
  int w_mat [M][N];
  int gold  [M];
  int x_mem [N];
  int acc   [P];

  always #5 clk = ~clk;

  mvm_layer_ctrl #(
    .M       (M),
    .N       (N),
    .P       (P),
    .MAC_LAT (MAC_LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .s_valid_x (s_valid_x),
    .s_ready_x (s_ready_x),
    .m_valid_y (m_valid_y),
    .m_ready_y (m_ready_y),
    .x_wr_en   (x_wr_en),
    .x_addr    (x_addr),
    .w_addr    (w_addr),
    .mac_en    (mac_en),
    .mac_clear (mac_clear),
    .out_sel   (out_sel)
  );

  task automatic new_vector();
    for (int c = 0; c < N; c++) x_vec[c] = int'($urandom_range(0, 255));
    for (int r = 0; r < M; r++) begin
      gold[r] = 0;
      for (int c = 0; c < N; c++) begin
        w_mat[r][c] = int'($urandom_range(0, 255));
        gold[r] += w_mat[r][c] * x_vec[c];
      end
    end
  endtask

  // ROM j holds row (a/N)*P+j, column a%N at address a.
  function automatic int rom(input int j, input int a);
    if (a >= int'(NPASS * N)) return 0;
    return w_mat[(a / int'(N)) * int'(P) + j][a % int'(N)];
  endfunction

  task automatic do_reset();
    reset     = 1'b1;
    s_valid_x = 1'b0;
    m_ready_y = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Starts at posedge+1 with the DUT in LOAD; returns at posedge+1 after the last output.
  task automatic run_vector(input int vmode, input int rmode, output int cycles);
    int sent, macs, hs, cyc, load_done, first_mac, xv;
    bit prev_stall, done;
    logic [SW-1:0] prev_sel;
    sent = 0; macs = 0; hs = 0; cyc = 0; load_done = -10; first_mac = -20;
    prev_stall = 0; done = 0; prev_sel = '0;
    new_vector();
    while (!done && cyc < 4000) begin
      case (vmode)
        0:       s_valid_x = 1'b1;
        1:       s_valid_x = (cyc % 2 == 0);
        default: s_valid_x = 1'($urandom_range(0, 1));
      endcase
      m_ready_y = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clk);
      n_total++;
      if (x_wr_en !== (s_valid_x & s_ready_x)) begin
        n_bad++;
        $display("FAIL x_wr_en_rule cyc=%0d got=%b valid=%b ready=%b", cyc, x_wr_en, s_valid_x,
                 s_ready_x);
      end
      if (x_wr_en === 1'b1) begin
        n_total++;
        if (sent >= int'(N) || x_addr !== XAW'(sent)) begin
          n_bad++;
          $display("FAIL load_addr cyc=%0d got=%0d want=%0d", cyc, x_addr, sent);
        end
        if (sent < int'(N) && x_addr < N) x_mem[x_addr] = x_vec[sent];
        sent++;
        if (sent == int'(N)) load_done = cyc;
      end
      if (mac_en === 1'b1) begin
        if (macs == 0) first_mac = cyc;
        n_total++;
        if (x_addr !== XAW'(macs % int'(N)) || w_addr !== WAW'(macs) ||
            mac_clear !== (macs % int'(N) == 0)) begin
          n_bad++;
          $display("FAIL mac_issue #%0d got x=%0d w=%0d clr=%b want x=%0d w=%0d clr=%b", macs,
                   x_addr, w_addr, mac_clear, macs % int'(N), macs, (macs % int'(N) == 0));
        end
        xv = (x_addr < N) ? x_mem[x_addr] : 0;
        for (int j = 0; j < int'(P); j++) begin
          acc[j] = (mac_clear ? 0 : acc[j]) + rom(j, int'(w_addr)) * xv;
        end
        macs++;
      end
      if (prev_stall) begin
        n_total++;
        if (m_valid_y !== 1'b1 || out_sel !== prev_sel) begin
          n_bad++;
          $display("FAIL stall_hold cyc=%0d got valid=%b sel=%0d want valid=1 sel=%0d", cyc,
                   m_valid_y, out_sel, prev_sel);
        end
      end
      if (m_valid_y === 1'b1) begin
        n_total++;
        if (x_wr_en !== 1'b0 || s_ready_x !== 1'b0) begin
          n_bad++;
          $display("FAIL load_in_output cyc=%0d got wr=%b rdy=%b want 0 0", cyc, x_wr_en,
                   s_ready_x);
        end
        if (m_ready_y) begin
          n_total++;
          if (out_sel !== SW'(hs % int'(P)) || acc[out_sel] !== gold[hs]) begin
            n_bad++;
            $display("FAIL y_out #%0d got sel=%0d y=%0d want sel=%0d y=%0d", hs, out_sel,
                     acc[out_sel], hs % int'(P), gold[hs]);
          end
          hs++;
        end
      end
      prev_stall = (m_valid_y === 1'b1) && !m_ready_y;
      prev_sel   = out_sel;
      @(posedge clk); #1;
      cyc++;
      if (hs == int'(M)) done = 1;
    end
    if (!done) begin
      n_total++;
      n_bad++;
      $display("FAIL timeout got hs=%0d want %0d", hs, M);
    end
    n_total++;
    if (s_ready_x !== 1'b1 || m_valid_y !== 1'b0) begin
      n_bad++;
      $display("FAIL ready_return got rdy=%b vld=%b want 1 0", s_ready_x, m_valid_y);
    end
    n_total++;
    if (sent != int'(N) || macs != int'(NPASS * N)) begin
      n_bad++;
      $display("FAIL counts got loads=%0d macs=%0d want %0d %0d", sent, macs, N, NPASS * N);
    end
    n_total++;
    if (first_mac != load_done + 1) begin
      n_bad++;
      $display("FAIL compute_entry got first_mac=%0d want %0d", first_mac, load_done + 1);
    end
    cycles = cyc;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    s_valid_x = 1'b1;
    m_ready_y = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      n_total++;
      if (s_ready_x !== 1'b1 || m_valid_y !== 1'b0 || mac_en !== 1'b0 || x_wr_en !== 1'b0 ||
          mac_clear !== 1'b0 || x_addr !== '0 || w_addr !== '0 || out_sel !== '0) begin
        n_bad++;
        $display("FAIL reset_vals got rdy=%b vld=%b mac=%b wr=%b clr=%b xa=%0d wa=%0d sel=%0d",
                 s_ready_x, m_valid_y, mac_en, x_wr_en, mac_clear, x_addr, w_addr, out_sel);
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_total++;
    if (x_wr_en !== 1'b1 || x_addr !== '0 || s_ready_x !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release got wr=%b xa=%0d rdy=%b want 1 0 1", x_wr_en, x_addr,
               s_ready_x);
    end
    do_reset();
  endtask

  task automatic test_full_rate();
    int cyc;
    run_vector(0, 0, cyc);
    n_total++;
    if (cyc != VEC_CYCLES) begin
      n_bad++;
      $display("FAIL full_rate_latency got=%0d want=%0d", cyc, VEC_CYCLES);
    end
  endtask

  task automatic test_valid_toggle();
    int cyc;
    run_vector(1, 0, cyc);
    n_total++;
    if (cyc != VEC_CYCLES + int'(N) - 1) begin
      n_bad++;
      $display("FAIL toggle_latency got=%0d want=%0d", cyc, VEC_CYCLES + int'(N) - 1);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    run_vector(2, 1, cyc);
    run_vector(0, 1, cyc);
  endtask

  task automatic test_mid_reset();
    int  cyc;
    bit  found;
    found     = 0;
    s_valid_x = 1'b1;
    m_ready_y = 1'b1;
    new_vector();
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      if (mac_en === 1'b1 && w_addr === WAW'(2 * N + 5)) found = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    n_total++;
    if (!found) begin
      n_bad++;
      $display("FAIL mid_reset_reach got none want w_addr=%0d in compute", 2 * N + 5);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset     = 1'b0;
    s_valid_x = 1'b0;
    @(negedge clk);
    n_total++;
    if (s_ready_x !== 1'b1 || m_valid_y !== 1'b0 || mac_en !== 1'b0 || x_wr_en !== 1'b0 ||
        mac_clear !== 1'b0 || x_addr !== '0 || w_addr !== '0 || out_sel !== '0) begin
      n_bad++;
      $display("FAIL mid_reset_vals got rdy=%b vld=%b mac=%b wr=%b clr=%b xa=%0d wa=%0d sel=%0d",
               s_ready_x, m_valid_y, mac_en, x_wr_en, mac_clear, x_addr, w_addr, out_sel);
    end
    @(posedge clk); #1;
    run_vector(2, 1, cyc);
  endtask

  task automatic test_back_to_back();
    int cyc;
    for (int v = 0; v < 2; v++) begin
      run_vector(0, 0, cyc);
      n_total++;
      if (cyc != VEC_CYCLES) begin
        n_bad++;
        $display("FAIL b2b_latency vec=%0d got=%0d want=%0d", v, cyc, VEC_CYCLES);
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    s_valid_x = 1'b0;
    m_ready_y = 1'b0;
    for (int j = 0; j < int'(P); j++) acc[j] = 0;
    for (int c = 0; c < int'(N); c++) x_mem[c] = 0;
    test_reset();
    test_full_rate();
    test_valid_toggle();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
